// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the datapath / select-encode stage.
// The sequencer is the master: it consumes opcode and mem_ready and drives every strobe.
interface control_sequencer_if;
    logic [4:0] opcode;
    logic       mem_ready;
    logic       Gra, Grb, Grc;
    logic       Rin, Rout, BAout, Cout;
    logic       PCout, PCin, IncPC, IRin;
    logic       MARin, MDRin, MDRout;
    logic       Read, Write;
    logic       Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [4:0] alu_op;
    logic       run;

    modport master (
        input  opcode, mem_ready,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
               PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
               Read, Write, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
               alu_op, run
    );

    modport slave (
        output opcode, mem_ready,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
               PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
               Read, Write, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
               alu_op, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch in T0-T2, per-class execute in T3-T7.
// Moore outputs decoded from the state and the opcode captured in T3.
module control_sequencer (
    input  logic                 clock,
    input  logic                 reset,
    control_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MUL, C_NEG, C_HALT, C_NONE
    } cls_t;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, baout, cout;
        logic pcout, pcin, incpc, irin;
        logic marin, mdrin, mdrout, rd, wr;
        logic yin, zin, zlowout, zhighout, hiin, loin;
    } ctl_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    state_t     state, state_nxt;
    cls_t       cls;
    ctl_t       ctl;
    logic [4:0] alu;
    logic       run;
    logic [4:0] op_q;
    logic [4:0] cur_op;
    logic       fetch_wait;

    function automatic cls_t decode(input logic [4:0] op);
        cls_t c;
        case (op) inside
            [5'b00011:5'b01011]: c = C_ALU;
            [5'b01100:5'b01110]: c = C_IMM;
            5'b00001:            c = C_LDI;
            5'b00000:            c = C_LD;
            5'b00010:            c = C_ST;
            5'b01111, 5'b10000:  c = C_MUL;
            5'b10001, 5'b10010:  c = C_NEG;
            5'b11011:            c = C_HALT;
            default:             c = C_NONE;
        endcase
        return c;
    endfunction

    // During T3 the live opcode is decoded; afterwards only the captured copy matters.
    assign cur_op = (state == S_T3) ? bus.opcode : op_q;
    assign cls    = decode(cur_op);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_RST;
            fetch_wait <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_wait <= (state == S_T1) && !bus.mem_ready;
        end
    end

    always_ff @(posedge clock) begin
        if (state == S_T3)
            op_q <= bus.opcode;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:  state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   state_nxt = bus.mem_ready ? S_T2 : S_T1;
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                case (cls)
                    C_HALT:  state_nxt = S_HALT;
                    C_NONE:  state_nxt = S_T0;
                    default: state_nxt = S_T4;
                endcase
            end
            S_T4:   state_nxt = (cls == C_NEG) ? S_T0 : S_T5;
            S_T5:   state_nxt = (cls == C_LD || cls == C_ST || cls == C_MUL) ? S_T6 : S_T0;
            S_T6: begin
                case (cls)
                    C_LD:    state_nxt = bus.mem_ready ? S_T7 : S_T6;
                    C_ST:    state_nxt = S_T7;
                    default: state_nxt = S_T0;
                endcase
            end
            S_T7: begin
                if (cls == C_ST)
                    state_nxt = bus.mem_ready ? S_T0 : S_T7;
                else
                    state_nxt = S_T0;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        ctl = '0;
        alu = ALU_ADD;
        run = (state != S_HALT);
        case (state)
            S_T0: begin
                ctl.pcout = 1'b1; ctl.marin = 1'b1; ctl.incpc = 1'b1; ctl.zin = 1'b1;
            end
            S_T1: begin
                // PC is reloaded only once even if the fetch read stalls.
                ctl.zlowout = 1'b1; ctl.pcin = !fetch_wait; ctl.rd = 1'b1; ctl.mdrin = 1'b1;
            end
            S_T2: begin
                ctl.mdrout = 1'b1; ctl.irin = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALU, C_IMM: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.yin = 1'b1; end
                    C_LDI, C_LD, C_ST: begin ctl.grb = 1'b1; ctl.baout = 1'b1; ctl.yin = 1'b1; end
                    C_MUL: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.yin = 1'b1; end
                    C_NEG: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.zin = 1'b1; alu = cur_op; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU: begin ctl.grc = 1'b1; ctl.rout = 1'b1; ctl.zin = 1'b1; alu = cur_op; end
                    C_IMM: begin ctl.cout = 1'b1; ctl.zin = 1'b1; alu = cur_op; end
                    C_LDI, C_LD, C_ST: begin ctl.cout = 1'b1; ctl.zin = 1'b1; end
                    C_MUL: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.zin = 1'b1; alu = cur_op; end
                    C_NEG: begin ctl.zlowout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU, C_IMM, C_LDI: begin ctl.zlowout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                    C_LD, C_ST: begin ctl.zlowout = 1'b1; ctl.marin = 1'b1; end
                    C_MUL: begin ctl.zlowout = 1'b1; ctl.loin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD:  begin ctl.rd = 1'b1; ctl.mdrin = 1'b1; end
                    C_ST:  begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.mdrin = 1'b1; end
                    C_MUL: begin ctl.zhighout = 1'b1; ctl.hiin = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin ctl.mdrout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                    C_ST: ctl.wr = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.Gra      = ctl.gra;
    assign bus.Grb      = ctl.grb;
    assign bus.Grc      = ctl.grc;
    assign bus.Rin      = ctl.rin;
    assign bus.Rout     = ctl.rout;
    assign bus.BAout    = ctl.baout;
    assign bus.Cout     = ctl.cout;
    assign bus.PCout    = ctl.pcout;
    assign bus.PCin     = ctl.pcin;
    assign bus.IncPC    = ctl.incpc;
    assign bus.IRin     = ctl.irin;
    assign bus.MARin    = ctl.marin;
    assign bus.MDRin    = ctl.mdrin;
    assign bus.MDRout   = ctl.mdrout;
    assign bus.Read     = ctl.rd;
    assign bus.Write    = ctl.wr;
    assign bus.Yin      = ctl.yin;
    assign bus.Zin      = ctl.zin;
    assign bus.Zlowout  = ctl.zlowout;
    assign bus.Zhighout = ctl.zhighout;
    assign bus.HIin     = ctl.hiin;
    assign bus.LOin     = ctl.loin;
    assign bus.alu_op   = alu;
    assign bus.run      = run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed cycle-by-cycle trace bench for control_sequencer: a table of per-cycle
// expectations for whole instructions, then hand sequences for halt and async reset.
module tb_control_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    localparam logic [21:0] GRA   = 22'(1) << 21;
    localparam logic [21:0] GRB   = 22'(1) << 20;
    localparam logic [21:0] GRC   = 22'(1) << 19;
    localparam logic [21:0] RIN   = 22'(1) << 18;
    localparam logic [21:0] ROUT  = 22'(1) << 17;
    localparam logic [21:0] BAOUT = 22'(1) << 16;
    localparam logic [21:0] COUT  = 22'(1) << 15;
    localparam logic [21:0] PCOUT = 22'(1) << 14;
    localparam logic [21:0] PCIN  = 22'(1) << 13;
    localparam logic [21:0] INCPC = 22'(1) << 12;
    localparam logic [21:0] IRIN  = 22'(1) << 11;
    localparam logic [21:0] MARIN = 22'(1) << 10;
    localparam logic [21:0] MDRIN = 22'(1) << 9;
    localparam logic [21:0] MDROUT= 22'(1) << 8;
    localparam logic [21:0] READ  = 22'(1) << 7;
    localparam logic [21:0] WRITE = 22'(1) << 6;
    localparam logic [21:0] YIN   = 22'(1) << 5;
    localparam logic [21:0] ZIN   = 22'(1) << 4;
    localparam logic [21:0] ZLO   = 22'(1) << 3;
    localparam logic [21:0] ZHI   = 22'(1) << 2;
    localparam logic [21:0] HIIN  = 22'(1) << 1;
    localparam logic [21:0] LOIN  = 22'(1) << 0;
    localparam logic [21:0] NONE  = 22'(0);

    localparam logic [21:0] F0  = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [21:0] F1  = ZLO | PCIN | READ | MDRIN;
    localparam logic [21:0] F1W = ZLO | READ | MDRIN;
    localparam logic [21:0] F2  = MDROUT | IRIN;
    localparam logic [4:0]  ADD = 5'b00011;

    typedef struct {
        bit [63:0]  name;
        logic [4:0] opcode;
        logic       mem_ready;
        logic [21:0] ctl;
        logic [4:0] alu;
        logic       run;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [21:0] actual_ctl();
        return {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Cout,
                bus.PCout, bus.PCin, bus.IncPC, bus.IRin, bus.MARin, bus.MDRin, bus.MDRout,
                bus.Read, bus.Write, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout,
                bus.HIin, bus.LOin};
    endfunction

    task automatic add(input bit [63:0] n, input logic [4:0] op, input logic mr,
                       input logic [21:0] c, input logic [4:0] a);
        vec_t v;
        v.name = n; v.opcode = op; v.mem_ready = mr; v.ctl = c; v.alu = a; v.run = 1'b1;
        tbl.push_back(v);
    endtask

    task automatic fetch(input bit [63:0] n);
        add(n, 5'b00000, 1'b1, F0, ADD);
        add(n, 5'b00000, 1'b1, F1, ADD);
        add(n, 5'b00000, 1'b1, F2, ADD);
    endtask

    task automatic check(input bit [63:0] n, input logic [21:0] ec, input logic [4:0] ea,
                         input logic er);
        checks++;
        if (actual_ctl() !== ec || bus.alu_op !== ea || bus.run !== er) begin
            errors++;
            $display("FAIL %0s @%0t: got ctl=%h alu=%b run=%b, want ctl=%h alu=%b run=%b",
                     n, $time, actual_ctl(), bus.alu_op, bus.run, ec, ea, er);
        end
    endtask

    task automatic step(input bit [63:0] n, input logic [4:0] op, input logic mr,
                        input logic [21:0] c, input logic [4:0] a, input logic r);
        @(negedge clock);
        bus.opcode = op;
        bus.mem_ready = mr;
        #1;
        check(n, c, a, r);
    endtask

    initial begin
        bus.opcode = 5'b00000;
        bus.mem_ready = 1'b1;

        // add: back at T0 on cycle 7 (the next fetch row)
        fetch("add");
        add("add_t3", 5'b00011, 1'b1, GRB | ROUT | YIN, ADD);
        add("add_t4", 5'b11011, 1'b1, GRC | ROUT | ZIN, 5'b00011);
        add("add_t5", 5'b11011, 1'b1, ZLO | GRA | RIN, ADD);
        // ld with three memory stalls in T6
        fetch("ld");
        add("ld_t3",  5'b00000, 1'b1, GRB | BAOUT | YIN, ADD);
        add("ld_t4",  5'b00000, 1'b0, COUT | ZIN, ADD);
        add("ld_t5",  5'b00000, 1'b0, ZLO | MARIN, ADD);
        add("ld_t6w", 5'b00000, 1'b0, READ | MDRIN, ADD);
        add("ld_t6w", 5'b00000, 1'b0, READ | MDRIN, ADD);
        add("ld_t6w", 5'b00000, 1'b0, READ | MDRIN, ADD);
        add("ld_t6",  5'b00000, 1'b1, READ | MDRIN, ADD);
        add("ld_t7",  5'b00000, 1'b1, MDROUT | GRA | RIN, ADD);
        // st with a stalled fetch and a stalled write
        add("st_t0",  5'b00000, 1'b1, F0, ADD);
        add("st_t1",  5'b00000, 1'b0, F1, ADD);
        add("st_t1w", 5'b00000, 1'b0, F1W, ADD);
        add("st_t1w", 5'b00000, 1'b1, F1W, ADD);
        add("st_t2",  5'b00000, 1'b1, F2, ADD);
        add("st_t3",  5'b00010, 1'b1, GRB | BAOUT | YIN, ADD);
        add("st_t4",  5'b00000, 1'b1, COUT | ZIN, ADD);
        add("st_t5",  5'b00000, 1'b1, ZLO | MARIN, ADD);
        add("st_t6",  5'b00000, 1'b0, GRA | ROUT | MDRIN, ADD);
        add("st_t7w", 5'b00000, 1'b0, WRITE, ADD);
        add("st_t7w", 5'b00000, 1'b0, WRITE, ADD);
        add("st_t7",  5'b00000, 1'b1, WRITE, ADD);
        // mul: opcode forced to ld after T3 must not matter
        fetch("mul");
        add("mul_t3", 5'b01111, 1'b1, GRA | ROUT | YIN, ADD);
        add("mul_t4", 5'b00000, 1'b1, GRB | ROUT | ZIN, 5'b01111);
        add("mul_t5", 5'b00000, 1'b1, ZLO | LOIN, ADD);
        add("mul_t6", 5'b00000, 1'b1, ZHI | HIIN, ADD);
        fetch("addi");
        add("addi_t3", 5'b01100, 1'b1, GRB | ROUT | YIN, ADD);
        add("addi_t4", 5'b00000, 1'b1, COUT | ZIN, 5'b01100);
        add("addi_t5", 5'b00000, 1'b1, ZLO | GRA | RIN, ADD);
        fetch("ldi");
        add("ldi_t3", 5'b00001, 1'b1, GRB | BAOUT | YIN, ADD);
        add("ldi_t4", 5'b00000, 1'b1, COUT | ZIN, ADD);
        add("ldi_t5", 5'b00000, 1'b1, ZLO | GRA | RIN, ADD);
        fetch("not");
        add("not_t3", 5'b10010, 1'b1, GRB | ROUT | ZIN, 5'b10010);
        add("not_t4", 5'b00000, 1'b1, ZLO | GRA | RIN, ADD);
        fetch("undef");
        add("und_t3", 5'b11111, 1'b1, NONE, ADD);
        fetch("nop");
        add("nop_t3", 5'b11010, 1'b1, NONE, ADD);
        fetch("halt");
        add("hlt_t3", 5'b11011, 1'b1, NONE, ADD);

        @(negedge clock);
        #1;
        check("rst_hold", NONE, ADD, 1'b1);
        reset = 1'b0;

        foreach (tbl[i])
            step(tbl[i].name, tbl[i].opcode, tbl[i].mem_ready, tbl[i].ctl, tbl[i].alu, tbl[i].run);

        for (int k = 0; k < 22; k++)
            step("halted", 5'(k), 1'(k % 2), NONE, ADD, 1'b0);

        // Reset out of HALT restores run and restarts fetch
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("hlt_rst", NONE, ADD, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_rel", NONE, ADD, 1'b1);

        // ld interrupted by reset while stalled in T6
        step("rl_t0", 5'b00000, 1'b1, F0, ADD, 1'b1);
        step("rl_t1", 5'b00000, 1'b1, F1, ADD, 1'b1);
        step("rl_t2", 5'b00000, 1'b1, F2, ADD, 1'b1);
        step("rl_t3", 5'b00000, 1'b1, GRB | BAOUT | YIN, ADD, 1'b1);
        step("rl_t4", 5'b00000, 1'b1, COUT | ZIN, ADD, 1'b1);
        step("rl_t5", 5'b00000, 1'b1, ZLO | MARIN, ADD, 1'b1);
        step("rl_t6w", 5'b00000, 1'b0, READ | MDRIN, ADD, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rl_async", NONE, ADD, 1'b1);
        @(negedge clock);
        #1;
        check("rl_held", NONE, ADD, 1'b1);
        reset = 1'b0;
        step("rl_f0", 5'b00000, 1'b1, F0, ADD, 1'b1);
        step("rl_f1", 5'b00000, 1'b1, F1, ADD, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired multi-cycle control unit of the 32-bit datapath. Steps each instruction through fetch (T0–T2) and per-class execute states (T3–T7). Consumes the 5-bit opcode produced by the register select/encode stage and drives that stage's Gra/Grb/Grc/Rin/Rout/BAout/Cout strobes plus all datapath register, ALU and memory controls.

## Interface
Parameters:
- none

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; forces state RST immediately
- opcode  in  5  IR[31:27] from select/encode; sampled only in T3
- mem_ready  in  1  memory completion for the current Read/Write
- Gra, Grb, Grc  out  1 each  register-field selects to select/encode
- Rin, Rout, BAout, Cout  out  1 each  register in/out, base-address out, sign-extended C out
- PCout, PCin, IncPC, IRin  out  1 each  program counter / instruction register controls
- MARin, MDRin, MDRout  out  1 each  memory address/data register controls
- Read, Write  out  1 each  memory strobes
- Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  ALU operand/result register controls
- alu_op  out  5  ALU function, opcode encoding; 5'b00011 (add) when not otherwise stated
- run  out  1  high except in HALT

## Operation
- Clock and reset are decided: one clock; reset is asynchronous and active-high.
- States: RST, T0–T7, HALT. Outputs are Moore (decoded from state plus the opcode latched in T3). Every control not listed for a state is 0.
- RST: all controls 0, run=1. Next state is T0.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin. Holds in T1 while mem_ready=0, with PCin asserted only in the first T1 cycle.
- T2: MDRout, IRin.
- T3: opcode latched into an internal op register; class actions start here.
- Execute per opcode. The last listed state returns to T0.
  - add/sub/and/or/shr/shra/shl/ror/rol (00011–01011):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, alu_op=op, Zin.
    - T5: Zlowout, Gra, Rin.
  - addi/andi/ori (01100–01110):
    - T3: Grb, Rout, Yin.
    - T4: Cout, alu_op=op, Zin.
    - T5: Zlowout, Gra, Rin.
  - ldi (00001):
    - T3: Grb, BAout, Yin.
    - T4: Cout, Zin.
    - T5: Zlowout, Gra, Rin.
  - ld (00000): T3–T4 as ldi, then:
    - T5: Zlowout, MARin.
    - T6: Read, MDRin; waits on mem_ready.
    - T7: MDRout, Gra, Rin.
  - st (00010): T3–T5 as ld, then:
    - T6: Gra, Rout, MDRin.
    - T7: Write; waits on mem_ready.
  - mul/div (01111, 10000):
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, alu_op=op, Zin.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - neg/not (10001, 10010):
    - T3: Grb, Rout, alu_op=op, Zin.
    - T4: Zlowout, Gra, Rin.
  - halt (11011): T3 → HALT. HALT drives all controls 0 and run=0, and stays in HALT until reset.
  - All other opcodes (including nop 11010): T3 performs no action; T3 → T0.
- At most one of Gra/Grb/Grc is high in any state.
- At most one of Rin/Rout/BAout is high in any state.

## Timing
- Reset may assert in any state, including memory waits. Outputs go to their RST values combinationally; no partial register write persists past the reset edge.
- Cycle counts with mem_ready tied high:
  - ALU and immediate: 6 cycles.
  - ldi: 6 cycles.
  - neg/not: 5 cycles.
  - mul/div: 7 cycles.
  - ld/st: 8 cycles.
  - nop: 4 cycles.
- Each cycle of mem_ready=0 in T1, T6(ld) or T7(st) adds one cycle. Read/Write stay asserted and steady throughout the wait.
- mem_ready is ignored outside wait states.
- opcode changes after T3 have no effect; the latched op drives execute.

## Test plan
- Reset mid-ld: assert reset during T6 → all controls 0 at once. After release, T0 on the next edge: PCout=MARin=IncPC=Zin=1.
- add (opcode 00011), mem_ready=1:
  - T3: Grb+Rout+Yin.
  - T4: Grc+Rout+Zin, alu_op=00011.
  - T5: Gra+Rin+Zlowout.
  - Back at T0 on cycle 7.
- ld with mem_ready low for 3 cycles in T6 → Read+MDRin held for 4 cycles. T7 gives MDRout+Gra+Rin; total 11 cycles.
- st:
  - T6: Gra+Rout+MDRin.
  - T7: Write held until mem_ready.
  - Rin never asserted.
- mul (01111): LOin at T5, HIin at T6. opcode toggled to 00000 after T3 does not alter the sequence.
- halt (11011) → run=0 and controls stay 0 for 20+ cycles; reset restores run=1 and fetch resumes. Undefined opcode 11111 → T3 then T0, with no Rin/Write.
